memory_responder: RTL
=====================

// Module: memory_responder
// PURPOSE
//  Memory-side responder for the core's load/store data port: accepts one request per handshake,
//  inserts programmable wait states, performs RV32I byte/half/word access and returns the result.
//  Sits opposite the load and store units; replaces the zero-latency data memory in the rv32 bench.
// PARAMETERS
//  DEPTH_WORDS    1024  32-bit words of storage; byte addresses >= 4*DEPTH_WORDS are out of range
//  WAIT_STATES    2     cycles spent in WAIT per request (0..15)
//  INIT_FILE      ""    hex image loaded by $readmemh at time 0 when non-empty
// PORTS
//  clock                 in   1   single clock, all logic on rising edge
//  reset                 in   1   synchronous, active-high
//  request_valid         in   1   initiator presents a request
//  request_ready         out  1   responder can accept (IDLE only)
//  request_write         in   1   1 = store, 0 = load
//  request_address       in   32  byte address
//  request_funct3        in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  request_write_value   in   32  store data, right-aligned (rs2_value)
//  response_valid        out  1   result available; held until accepted
//  response_ready        in   1   initiator accepts response
//  response_read_value   out  32  extended load data; 0 for stores and errors
//  response_error        out  1   misaligned, out-of-range or illegal funct3
// BEHAVIOUR
//  - Reset: state IDLE, request_ready=1, response_valid=0, response_read_value=0, response_error=0,
//    wait counter 0. Storage array is NOT cleared by reset.
//  - FSM IDLE->WAIT on request_valid&&request_ready (request fields latched that edge);
//    WAIT->RESPOND when counter==WAIT_STATES (WAIT_STATES=0: one WAIT cycle skipped, go direct);
//    RESPOND->IDLE on response_valid&&response_ready. request_ready=0 outside IDLE.
//  - Latency: accept at edge N -> response_valid high from cycle N+WAIT_STATES+1.
//    Throughput one request per WAIT_STATES+2 cycles minimum (no overlap).
//  - Store commit: byte lanes written on WAIT->RESPOND edge only; SB lane=addr[1:0], SH lanes
//    addr[1]*2..+1, SW all four; unaffected bytes preserved.
//  - Load: word read on WAIT->RESPOND edge; LB/LH sign-extend, LBU/LHU zero-extend selected lane.
//  - Error: load funct3 in {3,6,7} or store funct3>2 illegal; out of range -> error=1, no write,
//    read_value=0. Response still handshakes normally.
//  - response_valid/value/error stable while response_ready=0 (no change until accepted).
//  - request_valid dropped before accept: nothing happens. Inputs ignored outside IDLE.
//  - Reset mid-operation: returns to IDLE next edge; a store not yet committed is discarded.
// CONFIGURATION
//  MEMORY_RESPONDER_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0
//    -> response_error=1, no access.
//  Not defined: low address bits beyond the access size are masked (access forced aligned),
//    misalignment never raises error; range/funct3 errors still reported.
// STRUCTURE
//  Package rv32_memory_pkg: funct3 localparams (F3_LB=0,F3_LH=1,F3_LW=2,F3_LBU=4,F3_LHU=5,
//    F3_SB=0,F3_SH=1,F3_SW=2), FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESPOND=2'd2).
//  Sub-module memory_lane_align (combinational): from funct3, addr[1:0], stored word, store data
//    produce 4-bit byte-enable, merged write word, extended load value, misalign flag.
//  Top: FSM, wait counter, request latch, storage array, response registers.
// TESTING
//  1. Reset, WAIT_STATES=2, SW 0x1234_5678 @0x10 -> response_valid at accept+3, error=0, value=0.
//  2. LB @0x13 after (1) -> 0x0000_0012; LB @0x10 of 0x8000_0080 -> 0xFFFF_FF80, LBU -> 0x80.
//  3. SB 0xAB @0x11 over 0x1234_5678 then LW @0x10 -> 0x1234_AB78; SH 0xBEEF @0x12 -> 0xBEEF_AB78.
//  4. Hold response_ready=0 for 5 cycles -> valid/value unchanged, request_ready=0; accept -> IDLE.
//  5. LW @0x12 with MISALIGN_CHECK_EN -> error=1, value=0; without -> reads word @0x10.
//  6. Out-of-range SW @4*DEPTH_WORDS -> error=1, no write; reset during WAIT of SW -> no write,
//     IDLE next cycle, request_ready=1.

Source files
------------

// File: rtl/rv32_memory_pkg.sv
// Shared definitions for the load/store memory responder: RV32I funct3
// codes, responder FSM states and the funct3 legality rule.
package rv32_memory_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Loads accept LB/LH/LW/LBU/LHU; stores accept SB/SH/SW only.
    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return funct3 <= F3_SW;
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/memory_lane_align.sv
// Byte-lane steering for RV32I loads and stores: derives byte enables,
// the merged store word and the extended load value from funct3 and the
// low address bits. The lane offset is always forced to the access size.
// Config macro: MEMORY_RESPONDER_MISALIGN_CHECK_EN -- when defined,
// misalign reports unaligned half/word accesses; otherwise it stays 0.
module memory_lane_align
    import rv32_memory_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] stored_word,
    input  logic [31:0] store_data,
    output logic [3:0]  byte_enable,
    output logic [31:0] write_word,
    output logic [31:0] load_value,
    output logic        misalign
);

    logic [1:0]  lane;
    logic [31:0] replicated;
    logic [31:0] shifted;
    logic        offset_unaligned;

    // Size decode: lane selection, byte enables and replicated store data
    always_comb begin
        lane             = '0;
        byte_enable      = '0;
        replicated       = store_data;
        offset_unaligned = 1'b0;
        case (funct3[1:0])
            2'd0: begin
                lane        = offset;
                byte_enable = 4'b0001 << offset;
                replicated  = {4{store_data[7:0]}};
            end
            2'd1: begin
                lane             = {offset[1], 1'b0};
                byte_enable      = offset[1] ? 4'b1100 : 4'b0011;
                replicated       = {2{store_data[15:0]}};
                offset_unaligned = offset[0];
            end
            2'd2: begin
                lane             = 2'd0;
                byte_enable      = 4'b1111;
                offset_unaligned = (offset != 2'd0);
            end
            default: ;
        endcase
    end

    // Merge enabled lanes of the store data over the stored word
    always_comb begin
        write_word = stored_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_enable[i])
                write_word[8*i +: 8] = replicated[8*i +: 8];
        end
    end

    // Extract and sign/zero-extend the selected load lane
    always_comb begin
        shifted = stored_word >> {lane, 3'b000};
        case (funct3)
            F3_LB:   load_value = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_value = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_value = {24'd0, shifted[7:0]};
            F3_LHU:  load_value = {16'd0, shifted[15:0]};
            default: load_value = stored_word;
        endcase
    end

`ifdef MEMORY_RESPONDER_MISALIGN_CHECK_EN
    assign misalign = offset_unaligned;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder for the core's load/store data port. One request
// per handshake, WAIT_STATES wait cycles, then the access is performed on
// the WAIT->RESPOND edge and the response is held until accepted.
// Config macro: MEMORY_RESPONDER_MISALIGN_CHECK_EN (misaligned accesses
// become errors; otherwise they are silently aligned).
module memory_responder
  import rv32_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [31:0] request_address,
  input  logic [2:0]  request_funct3,
  input  logic [31:0] request_write_value,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] response_read_value,
  output logic        response_error
);

  localparam int unsigned INDEX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_STATES);

  state_t             state;
  state_t             state_next;
  logic [3:0]         wait_count;
  logic               accept;
  logic               commit;

  logic               latched_write;
  logic [31:0]        latched_address;
  logic [2:0]         latched_funct3;
  logic [31:0]        latched_write_value;

  logic               access_write;
  logic [31:0]        access_address;
  logic [2:0]         access_funct3;
  logic [31:0]        access_write_value;
  logic               access_error;

  logic [31:0]        mem [0:DEPTH_WORDS-1];
  logic [INDEX_W-1:0] word_index;
  logic [31:0]        stored_word;
  logic [3:0]         byte_enable;
  logic [31:0]        write_word;
  logic [31:0]        load_value;
  logic               misalign;

  assign request_ready  = (state == IDLE);
  assign response_valid = (state == RESPOND);
  assign accept         = request_valid && request_ready;
  // The access happens on the edge that enters RESPOND, from IDLE too when WAIT is bypassed
  assign commit         = (state_next == RESPOND) && (state != RESPOND);

  // With no wait states the access runs on the accept edge, so it must see the live inputs
  assign access_write       = (state == IDLE) ? request_write       : latched_write;
  assign access_address     = (state == IDLE) ? request_address     : latched_address;
  assign access_funct3      = (state == IDLE) ? request_funct3      : latched_funct3;
  assign access_write_value = (state == IDLE) ? request_write_value : latched_write_value;

  assign word_index  = access_address[INDEX_W+1:2];
  assign stored_word = mem[word_index];

  memory_lane_align u_align (
    .funct3      (access_funct3),
    .offset      (access_address[1:0]),
    .stored_word (stored_word),
    .store_data  (access_write_value),
    .byte_enable (byte_enable),
    .write_word  (write_word),
    .load_value  (load_value),
    .misalign    (misalign)
  );

  // Error classification: illegal funct3, out-of-range address, misalignment
  always_comb begin
    access_error = !funct3_legal(access_write, access_funct3) ||
                   ({1'b0, access_address} >= ADDR_LIMIT) || misalign;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_STATES == 0) ? RESPOND : WAIT;
      WAIT:    if (wait_count == WAIT_LAST) state_next = RESPOND;
      RESPOND: if (response_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wait counter: counts WAIT cycles, starting at 1 on the accept edge
  always_ff @(posedge clock) begin
    if (reset)
      wait_count <= '0;
    else if (accept)
      wait_count <= 4'd1;
    else if (state == WAIT)
      wait_count <= (wait_count == WAIT_LAST) ? '0 : wait_count + 4'd1;
  end

  // Request latch, captured on the accept edge
  always_ff @(posedge clock) begin
    if (reset) begin
      latched_write       <= 1'b0;
      latched_address     <= '0;
      latched_funct3      <= '0;
      latched_write_value <= '0;
    end else if (accept) begin
      latched_write       <= request_write;
      latched_address     <= request_address;
      latched_funct3      <= request_funct3;
      latched_write_value <= request_write_value;
    end
  end

  // Response registers, loaded on the access edge and held through RESPOND
  always_ff @(posedge clock) begin
    if (reset) begin
      response_read_value <= '0;
      response_error      <= 1'b0;
    end else if (commit) begin
      response_error      <= access_error;
      response_read_value <= (access_error || access_write) ? '0 : load_value;
    end
  end

  // Store commit; suppressed by errors and by reset landing on the commit edge
  always_ff @(posedge clock) begin
    if (!reset && commit && access_write && !access_error && (|byte_enable))
      mem[word_index] <= write_word;
  end

endmodule
